// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: FSM states, default widths
// and the sweep direction encoding.
package nco_pkg;

  localparam int INC_W_DEF   = 2;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Loadable dwell down-counter. A zero load value behaves as one, and the
// counter reloads its period automatically on the expiry cycle.
module nco_dwell_cnt #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] period_q, period_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] clamped;

  assign clamped  = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
  assign expire_o = en_i && (cnt_q == DWELL_W'(1));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      period_d = clamped;
      cnt_d    = clamped;
    end else if (en_i) begin
      cnt_d = expire_o ? period_q : cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for the NCO: accepts a start/stop/dwell/loop command and
// steps the NCO increment one unit per dwell period toward the stop value.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int INC_W   = INC_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [INC_W-1:0]   cmd_start_inc,
  input  logic [INC_W-1:0]   cmd_stop_inc,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               cmd_loop,
  input  logic               abort,
  output logic               EN,
  output logic [INC_W-1:0]   inc,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [INC_W-1:0]   start_q, start_d;
  logic [INC_W-1:0]   stop_q, stop_d;
  logic               loop_q, loop_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               cnt_load, cnt_en, expire;

  nco_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cmd_dwell),
    .en_i       (cnt_en),
    .expire_o   (expire)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign EN          = en_q;
  assign inc         = inc_q;
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    start_d  = start_q;
    stop_d   = stop_q;
    loop_d   = loop_q;
    inc_d    = inc_q;
    en_d     = en_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          start_d  = cmd_start_inc;
          stop_d   = cmd_stop_inc;
          loop_d   = cmd_loop;
          dir_d    = (cmd_stop_inc >= cmd_start_inc) ? DIR_UP : DIR_DOWN;
          inc_d    = cmd_start_inc;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a simultaneous dwell expiry and suppresses done/strobe.
        cnt_en = !abort;
        if (abort) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (expire) begin
          if (inc_q != stop_q) begin
            inc_d    = (dir_q == DIR_UP) ? inc_q + INC_W'(1) : inc_q - INC_W'(1);
            strobe_d = 1'b1;
          end else if (loop_q) begin
            inc_d    = start_q;
            strobe_d = 1'b1;
          end else begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      start_q  <= '0;
      stop_q   <= '0;
      loop_q   <= 1'b0;
      inc_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      loop_q   <= loop_d;
      inc_q    <= inc_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against an arithmetic model of the sweep schedule.
module tb_nco_sweep_ctrl;

  localparam int INC_W   = 2;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [INC_W-1:0]   cmd_start_inc;
  logic [INC_W-1:0]   cmd_stop_inc;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               cmd_loop;
  logic               abort;
  logic               EN;
  logic [INC_W-1:0]   inc;
  logic               busy;
  logic               step_strobe;
  logic               done;

  int checkCount = 0;
  int errorCount = 0;

  nco_sweep_ctrl #(.INC_W(INC_W), .DWELL_W(DWELL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_start_inc (cmd_start_inc),
    .cmd_stop_inc  (cmd_stop_inc),
    .cmd_dwell     (cmd_dwell),
    .cmd_loop      (cmd_loop),
    .abort         (abort),
    .EN            (EN),
    .inc           (inc),
    .busy          (busy),
    .step_strobe   (step_strobe),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag, input int expInc);
    checkOutput({tag, "_en"}, 32'(EN), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_strobe"}, 32'(step_strobe), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 1);
    checkOutput({tag, "_inc"}, 32'(inc), 32'(expInc));
  endtask

  // Present a command for one edge; returns positioned in the first RUN cycle.
  task automatic applyStimulus(input int s, input int e, input int dwl, input int lp);
    @(negedge clk);
    checkOutput("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_start_inc = INC_W'(s);
    cmd_stop_inc  = INC_W'(e);
    cmd_dwell     = DWELL_W'(dwl);
    cmd_loop      = lp[0];
    cmd_valid     = 1'b1;
    @(negedge clk);
    cmd_valid     = 1'b0;
  endtask

  // Model: value index = (cycle mod D*L) / D; strobe on each multiple of D after cycle 0.
  task automatic runSweep(input string tag, input int s, input int e, input int dwl,
                          input int abortAt);
    int d, len, total, n, idx, expInc, lastInc;
    bit expStr;
    d       = (dwl == 0) ? 1 : dwl;
    len     = ((e >= s) ? (e - s) : (s - e)) + 1;
    total   = d * len;
    n       = (abortAt > 0) ? abortAt : total;
    lastInc = s;
    for (int c = 0; c < n; c++) begin
      idx    = (c % total) / d;
      expInc = (e >= s) ? (s + idx) : (s - idx);
      expStr = (c > 0) && ((c % d) == 0);
      checkOutput({tag, "_en"}, 32'(EN), 1);
      checkOutput({tag, "_busy"}, 32'(busy), 1);
      checkOutput({tag, "_inc"}, 32'(inc), 32'(expInc));
      checkOutput({tag, "_strobe"}, 32'(step_strobe), 32'(expStr));
      checkOutput({tag, "_done_run"}, 32'(done), 0);
      checkOutput({tag, "_ready_run"}, 32'(cmd_ready), 0);
      lastInc = expInc;
      if (abortAt > 0 && c == n - 1) abort = 1'b1;
      @(negedge clk);
    end
    if (abortAt > 0) begin
      abort = 1'b0;
      checkIdleOutputs({tag, "_abort"}, lastInc);
    end else begin
      checkOutput({tag, "_done_pulse"}, 32'(done), 1);
      checkOutput({tag, "_en_off"}, 32'(EN), 0);
      checkOutput({tag, "_busy_off"}, 32'(busy), 0);
      checkOutput({tag, "_strobe_done"}, 32'(step_strobe), 0);
      checkOutput({tag, "_ready_done"}, 32'(cmd_ready), 0);
      @(negedge clk);
      checkIdleOutputs({tag, "_after"}, e);
    end
  endtask

  initial begin
    int s, e, dwl, lp, ab, total;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_start_inc = '0;
    cmd_stop_inc  = '0;
    cmd_dwell     = '0;
    cmd_loop      = 1'b0;
    abort         = 1'b0;
    #1;
    checkIdleOutputs("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    // Abort outside RUN must be ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkIdleOutputs("abort_idle", 0);

    applyStimulus(0, 3, 4, 0);
    runSweep("up", 0, 3, 4, 0);

    applyStimulus(3, 1, 0, 0);
    runSweep("down_d0", 3, 1, 0, 0);

    applyStimulus(1, 2, 2, 1);
    runSweep("loop_abort", 1, 2, 2, 7);

    applyStimulus(2, 2, 5, 0);
    runSweep("single", 2, 2, 5, 0);

    applyStimulus(2, 2, 3, 1);
    runSweep("single_loop", 2, 2, 3, 10);

    // Second command held valid through RUN and DONE; taken right after IDLE returns.
    applyStimulus(1, 3, 2, 0);
    cmd_start_inc = 2'd3;
    cmd_stop_inc  = 2'd0;
    cmd_dwell     = 16'd1;
    cmd_loop      = 1'b0;
    cmd_valid     = 1'b1;
    runSweep("bp_first", 1, 3, 2, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    runSweep("bp_second", 3, 0, 1, 0);

    // Reset in the middle of a sweep.
    applyStimulus(0, 3, 3, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_en", 32'(EN), 1);
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid_rst", 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2, 0, 1, 0);
    runSweep("post_rst", 2, 0, 1, 0);

    for (int t = 0; t < 10; t++) begin
      s     = int'($urandom_range(0, 3));
      e     = int'($urandom_range(0, 3));
      dwl   = int'($urandom_range(0, 4));
      lp    = int'($urandom_range(0, 1));
      total = ((dwl == 0) ? 1 : dwl) * (((e >= s) ? (e - s) : (s - e)) + 1);
      if (lp == 1) ab = int'($urandom_range(1, 2 * total + 3));
      else if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(1, total));
      else ab = 0;
      applyStimulus(s, e, dwl, lp);
      runSweep("rand", s, e, dwl, ab);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
